row_stack: RTL and testbench

Parametrised bank of DEPTH row registers, each WIDTH bits wide, holding the settled playfield of the Tetris board. Provides single-row write and combinational single-row read. Provides a multi-cycle line-clear engine that removes every completely filled row and collapses the rows above it downward. Sits between the piece-placement logic (writer) and the VGA/board renderer (reader), replacing the fixed-width enabled register used per row today.

---
 rtl/row_stack_pkg.sv | 13 +
 rtl/row_stack_regn.sv | 22 ++
 rtl/row_stack.sv | 131 +++++++++++++
 tb/tb_row_stack.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_stack_pkg.sv
// Shared board constants and line-clear FSM encodings for the playfield row bank.
package row_stack_pkg;

  localparam int BOARD_WIDTH = 10;
  localparam int BOARD_DEPTH = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/row_stack_regn.sv
// WIDTH-bit register with load enable and asynchronous active-high clear.
module regn #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  // Load on enable; clear immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q_q <= '0;
    else if (en) q_q <= d;
  end

  assign q = q_q;

endmodule

// File: rtl/row_stack.sv
// Playfield row bank: single-row write, combinational read, and a multi-cycle
// line-clear engine that drops full rows and collapses the stack downward.
module row_stack
  import row_stack_pkg::*;
#(
  parameter int WIDTH = BOARD_WIDTH,
  parameter int DEPTH = BOARD_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrEnabled,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData,
  input  logic             clearStart,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    clearedCount
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e               state_q;
  logic [AW-1:0]        idx_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;

  logic [DEPTH-1:0][WIDTH-1:0] row_q;
  logic [DEPTH-1:0][WIDTH-1:0] row_d;
  logic [DEPTH-1:0]            row_en;

  logic [WIDTH-1:0] scan_row;
  logic             row_full;
  logic             shift_en;
  logic             wr_ok;

  // Writes are only honoured while idle; a busy pass drops them.
  assign wr_ok    = (state_q == IDLE) && wrEnabled;
  assign shift_en = (state_q == SCAN) && row_full;

  // Per-row next-value select: write, shift-down from above, or zero at the top.
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    logic wr_hit;
    logic sh_hit;
    assign wr_hit = wr_ok && (wrAddr == AW'(i));
    assign sh_hit = shift_en && (AW'(i) >= idx_q);

    if (i == DEPTH - 1) begin : g_top
      assign row_d[i] = sh_hit ? '0 : wrData;
    end else begin : g_mid
      assign row_d[i] = sh_hit ? row_q[i+1] : wrData;
    end

    assign row_en[i] = wr_hit || sh_hit;

    regn #(.W(WIDTH)) u_row (
      .clk (clk),
      .rst (reset),
      .en  (row_en[i]),
      .d   (row_d[i]),
      .q   (row_q[i])
    );
  end

  // Read mux; addresses past the top of the board read as empty.
  always_comb begin
    rdData = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rdAddr == AW'(i)) rdData = row_q[i];
  end

  // Full-row detect on the row currently under the scan index.
  always_comb begin
    scan_row = '0;
    for (int i = 0; i < DEPTH; i++)
      if (idx_q == AW'(i)) scan_row = row_q[i];
  end
  assign row_full = &scan_row;

  // Line-clear FSM: index stays put after a collapse so the row that slid
  // down into this slot gets checked on the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clearStart) begin
            state_q <= SCAN;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (row_full) begin
            cnt_q <= cnt_q + CW'(1);
          end else if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign clearedCount = cnt_q;

endmodule

// File: tb/tb_row_stack.sv
// Directed bench for row_stack (WIDTH=10, DEPTH=20).
module tb_row_stack;

  localparam int W = 10;
  localparam int D = 20;

  logic         clk;
  logic         reset;
  logic         wrEnabled;
  logic [4:0]   wrAddr;
  logic [W-1:0] wrData;
  logic [4:0]   rdAddr;
  logic [W-1:0] rdData;
  logic         clearStart;
  logic         busy;
  logic         done;
  logic [4:0]   clearedCount;

  int tests;
  int fails;
  logic [W-1:0] exp_row [D];

  row_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .wrEnabled    (wrEnabled),
    .wrAddr       (wrAddr),
    .wrData       (wrData),
    .rdAddr       (rdAddr),
    .rdData       (rdData),
    .clearStart   (clearStart),
    .busy         (busy),
    .done         (done),
    .clearedCount (clearedCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_row(input int a, input logic [W-1:0] d);
    @(negedge clk);
    wrEnabled = 1'b1;
    wrAddr    = 5'(a);
    wrData    = d;
    @(negedge clk);
    wrEnabled = 1'b0;
  endtask

  task automatic clear_exp();
    for (int r = 0; r < D; r++) exp_row[r] = '0;
  endtask

  // Start a pass and count busy cycles; optionally write row 0 in the start
  // cycle, and optionally inject a write and restart request mid-pass.
  task automatic run_clear(input bit wr_at_start, input logic [W-1:0] wd,
                           input bit inject,
                           output int nb, output int nd, output int at);
    nb = 0; nd = 0; at = 0;
    @(negedge clk);
    clearStart = 1'b1;
    if (wr_at_start) begin
      wrEnabled = 1'b1; wrAddr = 5'd0; wrData = wd;
    end
    @(negedge clk);
    clearStart = 1'b0;
    wrEnabled  = 1'b0;
    while (busy === 1'b1 && nb < 200) begin
      nb++;
      if (done === 1'b1) begin nd++; at = nb; end
      if (inject && nb == 5) begin
        wrEnabled = 1'b1; wrAddr = 5'd5; wrData = 10'h3FF; clearStart = 1'b1;
      end
      if (inject && nb == 7) begin
        wrEnabled = 1'b0; clearStart = 1'b0;
      end
      @(negedge clk);
    end
    wrEnabled  = 1'b0;
    clearStart = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_ctl: busy=%b done=%b, want 0/0", busy, done);
    end
    tests++;
    if (clearedCount !== 5'd0) begin
      fails++; $display("FAIL reset_cnt: got %0d want 0", clearedCount);
    end
    for (int r = 0; r < D; r++) begin
      rdAddr = 5'(r); #1;
      tests++;
      if (rdData !== 10'h000) begin
        fails++; $display("FAIL reset_row%0d: got %h want 000", r, rdData);
      end
    end
  endtask

  task automatic test_write_read();
    do_reset();
    clear_exp();
    write_row(3, 10'h2A5);
    write_row(21, 10'h3FF);
    write_row(31, 10'h3FF);
    exp_row[3] = 10'h2A5;
    for (int r = 0; r < D; r++) begin
      rdAddr = 5'(r); #1;
      tests++;
      if (rdData !== exp_row[r]) begin
        fails++; $display("FAIL wr_row%0d: got %h want %h", r, rdData, exp_row[r]);
      end
    end
    rdAddr = 5'd21; #1;
    tests++;
    if (rdData !== 10'h000) begin
      fails++; $display("FAIL rd_oob21: got %h want 000", rdData);
    end
    rdAddr = 5'd31; #1;
    tests++;
    if (rdData !== 10'h000) begin
      fails++; $display("FAIL rd_oob31: got %h want 000", rdData);
    end
  endtask

  // Common checks after a pass: busy length, single done on last cycle, count, rows.
  task automatic test_clear(input string name, input int want_busy,
                            input int want_cnt, input bit wr_at_start,
                            input logic [W-1:0] wd, input bit inject);
    int nb, nd, at;
    run_clear(wr_at_start, wd, inject, nb, nd, at);
    tests++;
    if (nb != want_busy) begin
      fails++; $display("FAIL %s_busy: got %0d cycles want %0d", name, nb, want_busy);
    end
    tests++;
    if (nd != 1 || at != want_busy) begin
      fails++; $display("FAIL %s_done: pulses=%0d at=%0d want 1 at %0d", name, nd, at, want_busy);
    end
    tests++;
    if (clearedCount !== 5'(want_cnt)) begin
      fails++; $display("FAIL %s_cnt: got %0d want %0d", name, clearedCount, want_cnt);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL %s_idle: busy=%b want 0", name, busy);
    end
    for (int r = 0; r < D; r++) begin
      rdAddr = 5'(r); #1;
      tests++;
      if (rdData !== exp_row[r]) begin
        fails++; $display("FAIL %s_row%0d: got %h want %h", name, r, rdData, exp_row[r]);
      end
    end
  endtask

  task automatic test_single_clear();
    do_reset();
    write_row(0, 10'h3FF);
    write_row(1, 10'h001);
    clear_exp();
    exp_row[0] = 10'h001;
    test_clear("single", 22, 1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_stacked_clear();
    do_reset();
    for (int r = 0; r < 3; r++) write_row(r, 10'h3FF);
    write_row(3, 10'h155);
    clear_exp();
    exp_row[0] = 10'h155;
    test_clear("stacked", 24, 3, 1'b0, '0, 1'b0);
  endtask

  task automatic test_top_row();
    do_reset();
    write_row(19, 10'h3FF);
    clear_exp();
    test_clear("top", 22, 1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_all_full();
    do_reset();
    for (int r = 0; r < D; r++) write_row(r, 10'h3FF);
    clear_exp();
    test_clear("allfull", 41, 20, 1'b0, '0, 1'b0);
  endtask

  task automatic test_write_with_start();
    do_reset();
    write_row(1, 10'h0F0);
    clear_exp();
    exp_row[0] = 10'h0F0;
    test_clear("wrstart", 22, 1, 1'b1, 10'h3FF, 1'b0);
  endtask

  task automatic test_ignored_busy();
    do_reset();
    write_row(5, 10'h0AA);
    clear_exp();
    exp_row[5] = 10'h0AA;
    test_clear("ignore", 21, 0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_reset_midpass();
    do_reset();
    for (int r = 0; r < 3; r++) write_row(r, 10'h3FF);
    @(negedge clk);
    clearStart = 1'b1;
    @(negedge clk);
    clearStart = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || clearedCount !== 5'd3) begin
      fails++; $display("FAIL mid_prereset: busy=%b cnt=%0d want 1/3", busy, clearedCount);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || clearedCount !== 5'd0) begin
      fails++; $display("FAIL mid_async: busy=%b done=%b cnt=%0d want 0/0/0", busy, done, clearedCount);
    end
    for (int r = 0; r < 4; r++) begin
      rdAddr = 5'(r); #1;
      tests++;
      if (rdData !== 10'h000) begin
        fails++; $display("FAIL mid_row%0d: got %h want 000", r, rdData);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    clear_exp();
    test_clear("after", 21, 0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; wrEnabled = 1'b0; wrAddr = '0; wrData = '0;
    rdAddr = '0; clearStart = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || clearedCount !== 5'd0) begin
      fails++; $display("FAIL por: busy=%b cnt=%0d want 0/0", busy, clearedCount);
    end
    test_reset();
    test_write_read();
    test_single_clear();
    test_stacked_clear();
    test_top_row();
    test_all_full();
    test_write_with_start();
    test_ignored_busy();
    test_reset_midpass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
